// File: rtl/ecc_pkg.sv
// ecc_pkg: shared SEC-DED codeword types, widths and syndrome pattern helper
package ecc_pkg;
   localparam int DATA_W = 32;
   localparam int ECC_W  = 7;
   localparam int CW_W   = 39;
   typedef struct packed {
      logic [ECC_W-1:0]  ecc;
      logic [DATA_W-1:0] data;
   } cw_t;
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sbe;
      logic              dbe;
   } dec_res_t;
   // Data bit idx owns the idx-th non-power-of-two syndrome (3,5,6,7,9,...);
   // check bit j owns 1<<j, and ecc[6] is overall parity.
   function automatic logic [5:0] syn_pat(input int idx);
      int n;
      syn_pat = '0;
      n = 0;
      for (int p = 3; p < 64; p++)
         if ((p & (p - 1)) != 0) begin
            if (n == idx) syn_pat = p[5:0];
            n++;
         end
   endfunction
endpackage

// File: rtl/rvecc_decode.sv
// rvecc_decode: combinational SEC-DED decoder for {ecc[6:0], data[31:0]}
module rvecc_decode
   import ecc_pkg::*;
(
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   input  logic [ECC_W-1:0]  ecc_in,
   output logic [DATA_W-1:0] dout,
   output logic              single_ecc_error,
   output logic              double_ecc_error
);
   logic [5:0] syn;
   logic       par;
   // odd overall parity means one flipped bit; even parity with nonzero syndrome means two
   always_comb begin
      syn = ecc_in[5:0];
      for (int i = 0; i < DATA_W; i++) syn = syn ^ (din[i] ? syn_pat(i) : 6'd0);
      par = ^{ecc_in, din};
      dout = din;
      for (int i = 0; i < DATA_W; i++) if (en && par && syn == syn_pat(i)) dout[i] = ~din[i];
      single_ecc_error = en && par;
      double_ecc_error = en && !par && syn != 6'd0;
   end
endmodule

// File: rtl/ecc_rx_pipe.sv
// ecc_rx_pipe: 2-stage SEC-DED receive pipe with counters (ECC_RX_CNT_EN) and first-error log
module ecc_rx_pipe
   import ecc_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int TAG_W = 8
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CW_W-1:0]   in_codeword,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_sbe,
   output logic              out_dbe,
   output logic [CNT_W-1:0]  sbe_count,
   output logic [CNT_W-1:0]  dbe_count,
   input  logic              cnt_clr,
   output logic              log_valid,
   output logic              log_dbe,
   output logic [TAG_W-1:0]  log_tag,
   output logic [CW_W-1:0]   log_codeword,
   input  logic              log_clr
);
   cw_t              s1_cw, s2_cw;
   logic [TAG_W-1:0] s1_tag, s2_tag;
   logic             s1_valid, s2_valid, s1_adv, s2_adv, xfer;
   dec_res_t         dec, s2_res;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign xfer      = s2_valid && out_ready;
   assign out_valid = s2_valid;
   assign out_data  = s2_res.data;
   assign out_sbe   = s2_res.sbe;
   assign out_dbe   = s2_res.dbe;
   assign out_tag   = s2_tag;

   rvecc_decode u_dec (
      .en               (1'b1),
      .din              (s1_cw.data),
      .ecc_in           (s1_cw.ecc),
      .dout             (dec.data),
      .single_ecc_error (dec.sbe),
      .double_ecc_error (dec.dbe)
   );

   // pipeline registers; payload loads only with a valid word so stalls hold outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_tag   <= '0;
         s2_valid <= 1'b0;
         s2_cw    <= '0;
         s2_tag   <= '0;
         s2_res   <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_cw  <= cw_t'(in_codeword);
               s1_tag <= in_tag;
            end
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_cw  <= s1_cw;
               s2_tag <= s1_tag;
               s2_res <= dec;
            end
         end
      end
   end

`ifdef ECC_RX_CNT_EN
   // saturating error counters, bumped on output transfer; clear has priority
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbe_count <= '0;
         dbe_count <= '0;
      end else if (cnt_clr) begin
         sbe_count <= '0;
         dbe_count <= '0;
      end else if (xfer) begin
         if (out_sbe && sbe_count != '1) sbe_count <= sbe_count + CNT_W'(1);
         if (out_dbe && dbe_count != '1) dbe_count <= dbe_count + CNT_W'(1);
      end
   end
`else
   logic unused_cnt_clr;
   assign unused_cnt_clr = cnt_clr;
   assign sbe_count = '0;
   assign dbe_count = '0;
`endif

   // first-error log; clear has priority and re-arms capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         log_valid    <= 1'b0;
         log_dbe      <= 1'b0;
         log_tag      <= '0;
         log_codeword <= '0;
      end else if (log_clr) begin
         log_valid <= 1'b0;
      end else if (xfer && (out_sbe || out_dbe) && !log_valid) begin
         log_valid    <= 1'b1;
         log_dbe      <= out_dbe;
         log_tag      <= s2_tag;
         log_codeword <= s2_cw;
      end
   end
endmodule
